// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the multicycle divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam int DIV_LATENCY = DIV_STEPS + 2;
  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZERO} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] mag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  always_comb begin
    shifted = {rem_i, q_i[WIDTH-1]};
    trial = shifted - {1'b0, mag_i};
    rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: signed restoring divider, quotient to lo and remainder to hi.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int STEPS = DIV_STEPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             done,
  output logic             div_zero,
  output logic             busy
);
  localparam int CW = $clog2(STEPS) + 1;
  state_t state_q, state_d;
  logic armed_q, armed_d, sq_q, sq_d, sr_q, sr_d;
  logic done_q, done_d, dz_q, dz_d, busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, q_q, q_d, mag_q, mag_d, lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] step_rem, step_q;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .q_i(q_q), .mag_i(mag_q), .rem_o(step_rem), .q_o(step_q)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      q_q <= '0;
      mag_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      q_q <= q_d;
      mag_q <= mag_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      done_q <= done_d;
      dz_q <= dz_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    armed_d = start ? armed_q : 1'b1;
    cnt_d = cnt_q;
    rem_d = rem_q;
    q_d = q_q;
    mag_d = mag_q;
    sq_d = sq_q;
    sr_d = sr_q;
    lo_d = lo_q;
    hi_d = hi_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (start && armed_q) begin
        armed_d = 1'b0;
        if (divisor == '0) begin
          dz_d = 1'b1;
          state_d = ZERO;
        end else begin
          q_d = dividend[WIDTH-1] ? -dividend : dividend;
          mag_d = divisor[WIDTH-1] ? -divisor : divisor;
          rem_d = '0;
          sq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d = dividend[WIDTH-1];
          cnt_d = CW'(STEPS);
          busy_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        q_d = step_q;
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FIX : RUN;
      end
      FIX: begin
        lo_d = sq_q ? -q_q : q_q;
        hi_d = sr_q ? -rem_q : rem_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign lo = lo_q;
  assign hi = hi_q;
  assign done = done_q;
  assign div_zero = dz_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table and corner sequences against a result scoreboard.
module tb_div_unit;
  import div_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, lo, hi;
  logic done, div_zero, busy;
  int total = 0, bad = 0;
  typedef struct { logic [31:0] a, b, lo, hi; logic zero; } vec_t;
  typedef struct { logic [31:0] lo, hi; logic zero; } exp_t;
  exp_t sb[$];
  vec_t vt[10];
  div_unit dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .lo(lo), .hi(hi), .done(done), .div_zero(div_zero), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic wait_result(input int hold);
    exp_t e;
    int n = 0;
    bit got = 0;
    while (!got && n < DIV_LATENCY + 10) begin
      @(negedge clk);
      n++;
      if (n == 1 && !div_zero) chk("busy_run", 32'(busy), 1);
      if (done || div_zero) begin
        got = 1;
        e = sb.pop_front();
        chk("zero_flag", 32'(div_zero), 32'(e.zero));
        chk("done_flag", 32'(done), 32'(!e.zero));
        chk("latency", n, e.zero ? 1 : DIV_LATENCY);
        chk("busy_end", 32'(busy), 0);
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
      end
    end
    if (!got) begin
      chk("timeout", 1, 0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("pulse_once", 32'({done, div_zero}), 0);
      dividend = $urandom;
      divisor = $urandom;
    end
    start = 1'b0;
    @(negedge clk);
    chk("pulse_clear", 32'({done, div_zero}), 0);
  endtask
  task automatic run_div(input logic [31:0] a, b, elo, ehi, input logic ez);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    sb.push_back('{elo, ehi, ez});
    @(posedge clk);
    wait_result(0);
  endtask
  initial begin
    vt[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vt[1] = '{32'd5, 32'd0, 32'd14, 32'd2, 1'b1};
    vt[2] = '{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vt[3] = '{32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
    vt[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    vt[5] = '{32'd0, 32'd9, 32'd0, 32'd0, 1'b0};
    vt[6] = '{32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1'b0};
    vt[7] = '{32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0};
    vt[8] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0};
    vt[9] = '{32'd3, 32'd5, 32'd0, 32'd3, 1'b0};
    #1;
    chk("rst_lo", lo, 0);
    chk("rst_hi", hi, 0);
    chk("rst_flags", 32'({done, div_zero, busy}), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) run_div(vt[i].a, vt[i].b, vt[i].lo, vt[i].hi, vt[i].zero);
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    sb.push_back('{32'd14, 32'd2, 1'b0});
    for (int i = 0; i < 10; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_lo", lo, 0);
    chk("arst_hi", hi, 0);
    chk("arst_flags", 32'({done, div_zero, busy}), 0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    run_div(32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
    @(negedge clk);
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    sb.push_back('{32'd14, 32'd2, 1'b0});
    @(posedge clk);
    fork
      begin
        repeat (5) @(negedge clk);
        dividend = 32'd50;
        divisor = 32'd3;
      end
    join_none
    wait_result(10);
    run_div(32'd50, 32'd3, 32'd16, 32'd2, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
